pos_window_accum: RTL

Streaming windowed accumulator directly downstream of the positive gate stage. Consumes its signed non-negative samples over a valid/ready handshake and sums WINDOW samples with saturation. Presents the window sum on an output handshake and flags any negative sample that leaks through the gate. Used as the first clocked stage after the combinational gating logic.

---
 rtl/pos_pkg.sv | 15 +
 rtl/pos_window_accum_sat_add.sv | 28 ++
 rtl/pos_window_accum.sv | 118 +++++++++++
 3 files changed

// File: rtl/pos_pkg.sv
// Shared definitions for the positive-sample processing chain.
package pos_pkg;

  // Window accumulator control states.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Largest value representable in an unsigned field of sum_w bits.
  function automatic int unsigned sat_max(input int unsigned sum_w);
    return (32'd1 << sum_w) - 32'd1;
  endfunction

endpackage

// File: rtl/pos_window_accum_sat_add.sv
// Saturating adder: treats a negative sample as zero, zero-extends a
// non-negative one, adds it to the running sum and clamps at full scale.
module pos_window_accum_sat_add
  import pos_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int SUM_W  = 6
) (
  input  logic [SUM_W-1:0]  i_acc,
  input  logic [DATA_W-1:0] i_sample,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_sat
);

  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'(sat_max(SUM_W));

  logic [SUM_W:0] w_ext;
  logic [SUM_W:0] w_total;

  // One extra bit of headroom: a single add of a value below 2^SUM_W can
  // at most set the carry, so the carry alone signals overflow.
  assign w_ext   = i_sample[DATA_W-1] ? '0
                 : {{(SUM_W + 1 - DATA_W){1'b0}}, i_sample};
  assign w_total = {1'b0, i_acc} + w_ext;
  assign o_sat   = w_total[SUM_W];
  assign o_sum   = o_sat ? SAT_MAX : w_total[SUM_W-1:0];

endmodule

// File: rtl/pos_window_accum.sv
// Windowed saturating accumulator with valid/ready in and out.
// Sums WINDOW samples, then holds the result until the consumer takes it.
module pos_window_accum
  import pos_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int WINDOW = 4,
  parameter int SUM_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              neg_err
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat;
  logic [SUM_W-1:0]  r_out_sum;
  logic              r_out_sat;
  logic              r_neg_err;

  logic [SUM_W-1:0]  w_sum_add;
  logic              w_sat_add;
  logic              w_in_hs;
  logic              w_last;
  logic              w_neg;

  // Handshake flags are pure state decodes: no path from in_valid/out_ready.
  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_out_sum;
  assign out_sat   = r_out_sat;
  assign neg_err   = r_neg_err;

  assign w_in_hs = in_valid & in_ready;
  assign w_last  = (r_cnt == CNT_LAST);
  assign w_neg   = in_data[DATA_W-1];

  pos_window_accum_sat_add #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_sat_add (
    .i_acc    (r_sum),
    .i_sample (in_data),
    .o_sum    (w_sum_add),
    .o_sat    (w_sat_add)
  );

  // Next state: clr wins, otherwise fill a window then wait for the consumer.
  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = ACC;
    end else begin
      case (r_state)
        ACC:     if (w_in_hs && w_last) w_state_next = HOLD;
        HOLD:    if (out_ready)         w_state_next = ACC;
        default: w_state_next = ACC;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Accumulation, window completion and the sticky negative-sample flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_out_sum <= '0;
      r_out_sat <= 1'b0;
      r_neg_err <= 1'b0;
    end else if (clr) begin
      // Drop the partial window; the last published sum stays visible.
      r_sum     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_neg_err <= 1'b0;
    end else if (w_in_hs) begin
      if (w_neg) begin
        r_neg_err <= 1'b1;
      end
      if (w_last) begin
        r_out_sum <= w_sum_add;
        r_out_sat <= r_sat | w_sat_add;
        r_sum     <= '0;
        r_cnt     <= '0;
        r_sat     <= 1'b0;
      end else begin
        r_sum <= w_sum_add;
        r_sat <= r_sat | w_sat_add;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
